ifft8_seq: RTL
==============

# ifft8_seq

Sequential 8-point inverse FFT on IEEE-754 single-precision complex data, the receive-side counterpart of the team's combinational 8-point forward FFT. Accepts one 8-bin spectrum over a valid/ready handshake, then runs one radix-2 DIT butterfly per cycle through a single shared butterfly unit across 3 stages. Scales the result by 1/8 and presents 8 time-domain complex samples on a second valid/ready handshake. One transform is in flight at a time.

## Interface
- SCALE_EN, default 1: 1 applies the 1/8 scaling, 0 leaves the SCALE cycle as a pass-through. Latency is identical for both values.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_data holds a spectrum
- in_ready  out  1  block can accept a spectrum (IDLE only)
- in_data  in  512  bins X0..X7. X0 = [511:448] … X7 = [63:0]. Each 64-bit word is {re[63:32], im[31:0]}, fp32.
- out_valid  out  1  out_data holds a result
- out_ready  in  1  consumer accepts the result
- out_data  out  512  samples x0..x7, packed the same way as in_data
- busy  out  1  high in STAGE and SCALE

## Operation
- **FSM states:** IDLE, STAGE, SCALE, DONE.
- **IDLE:**
  - in_ready=1.
  - On in_valid&in_ready, store bin Xk into buffer entry bitrev3(k) (0,4,2,6,1,5,3,7).
  - Clear stage counter s and butterfly counter j, then go to STAGE.
- **STAGE:** one butterfly per cycle, in the order s=0..2, j=0..3.
  - span = 1<<s
  - pos = j & (span-1)
  - i = (j>>s)*2*span + pos, partner p = i+span
  - twiddle index k = pos<<(2-s)
  - t = buf[p] * WI[k]
  - buf[i] ← buf[i]+t, buf[p] ← buf[i]-t
  - After s=2, j=3, go to SCALE.
- **Twiddles (conjugate, W8^-k):**
  - WI0 = (3F800000, 00000000)
  - WI1 = (3F3504F3, 3F3504F3)
  - WI2 = (00000000, 3F800000)
  - WI3 = (BF3504F3, 3F3504F3)
- **Arithmetic:**
  - Uses the team's existing combinational complexMultiplier and complexAdder.
  - Subtraction is done by flipping the sign bits of both halves of t.
  - No rounding changes beyond those units.
- **SCALE (SCALE_EN=1):** applied per fp32 field in all 16 fields in one cycle, based on exponent e.
  - e=0xFF (inf/NaN): unchanged.
  - e≤3: flush to signed zero.
  - Otherwise: e−3.
  - Then go to DONE.
- **DONE:**
  - out_valid=1; out_data is driven directly from the buffer and held stable.
  - On out_valid&out_ready, go to IDLE.
- **Boundary cases:**
  - in_valid while not IDLE: ignored (in_ready=0).
  - out_ready held low: DONE holds indefinitely with no data change.
  - rst_n low in any state: immediately IDLE, buffer and counters cleared.
- **Reset values:**
  - in_ready=1 once rst_n is high.
  - out_valid=0, busy=0, out_data=0.

## Timing
- Accept at edge T.
- Butterflies written at edges T+1..T+12.
- SCALE writes at T+13, and out_valid is high from T+13.
- With out_ready=1, the handshake completes at T+14, in_ready=1 from T+14, and the next accept is at T+15.
- Minimum initiation interval: 15 cycles.
- in_ready and out_valid are never high together.
- All outputs are registered, or decoded from registered state only; there is no combinational in→out path.

## Structure
- **Package ifft_pkg:**
  - state enum
  - WI0..WI3 twiddle constants
  - fp32 field constants (sign bit 31, exponent [30:23], EXP_MAX=8'hFF)
  - bitrev3 function
  - fp32_div8 function
- **Sub-module ifft_butterfly** (combinational):
  - Inputs: a, b, twiddle index.
  - Outputs: a+b·WI, a−b·WI.
  - Wraps complexMultiplier and two complexAdder instances.
- **Top level:** FSM, counters, 8×64-bit buffer, index and address generation, scale logic.

## Test plan
- Impulse spectrum: all Xk=(1.0,0) → x0=(1.0,0), x1..x7=(0,0), out_valid exactly 13 cycles after accept.
- DC only: X0=(8.0,0), other bins 0 → all xn=(1.0,0) bit-exact (3F800000, 00000000).
- Shifted impulse: Xk=W8^k (forward twiddles, e.g. X1=(3F3504F3, BF3504F3)) → x1≈(1.0,0), other samples |re|,|im|≤1e-6.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_data unchanged every cycle, in_ready=0, in_valid pulses ignored. Release → handshake, then in_ready=1 the next cycle.
- Scaling edges: X0=(7F800000,0), other bins 0 → every re=7F800000. X0=(00800000,0) → all outputs flush to zero. With SCALE_EN=0 and DC X0=(8.0,0) → all outputs (8.0,0).
- Reset mid-operation: assert rst_n low during butterfly cycle 6 → asynchronously out_valid=0, busy=0, out_data=0. After release → in_ready=1, and the next transform is correct.

Source files
------------

// File: rtl/fp32_pkg.sv
// fp32 arithmetic shared by the complex units: round-to-nearest-even add and
// multiply, with subnormal inputs read as zero and subnormal results flushed.
package fp32_pkg;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    // a + b
    function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       l, s, res;
        logic [7:0]        d;
        logic [26:0]       ml, ms, mn;
        logic [27:0]       sum;
        logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, rnd;
        logic signed [9:0] ex;
        logic [24:0]       mr;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        l   = a;
        s   = b;
        d   = '0;
        ml  = '0;
        ms  = '0;
        mn  = '0;
        sum = '0;
        ex  = '0;
        mr  = '0;
        rnd = 1'b0;
        if (a_nan || b_nan)           res = FP_QNAN;
        else if (a_inf)               res = (b_inf && (a[31] != b[31])) ? FP_QNAN : a;
        else if (b_inf)               res = b;
        else if (a_zero && b_zero)    res = {a[31] & b[31], 31'd0};
        else if (a_zero)              res = b;
        else if (b_zero)              res = a;
        else begin
            if (b[30:0] > a[30:0]) begin
                l = b;
                s = a;
            end
            d  = l[30:23] - s[30:23];
            ml = {1'b1, l[22:0], 3'b000};
            ms = {1'b1, s[22:0], 3'b000};
            // align the smaller operand, folding lost bits into a sticky lsb
            if (d > 8'd26) ms = 27'd1;
            else           ms = (ms >> d) | {26'd0, |(ms & ((27'd1 << d) - 27'd1))};
            ex = $signed({2'b00, l[30:23]});
            if (l[31] == s[31]) begin
                sum = {1'b0, ml} + {1'b0, ms};
                if (sum[27]) begin
                    mn = {sum[27:2], sum[1] | sum[0]};
                    ex = ex + 10'sd1;
                end else begin
                    mn = sum[26:0];
                end
            end else begin
                mn = ml - ms;
                for (int k = 0; k < 26; k++) begin
                    if (!mn[26] && (mn != 27'd0)) begin
                        mn = mn << 1;
                        ex = ex - 10'sd1;
                    end
                end
            end
            rnd = mn[2] & (mn[1] | mn[0] | mn[3]);
            mr  = {1'b0, mn[26:3]} + {24'd0, rnd};
            if (mr[24]) begin
                mr = mr >> 1;
                ex = ex + 10'sd1;
            end
            if (mn == 27'd0)          res = 32'd0;
            else if (ex >= 10'sd255)  res = {l[31], 8'hFF, 23'd0};
            else if (ex <= 10'sd0)    res = {l[31], 31'd0};
            else                      res = {l[31], ex[7:0], mr[22:0]};
        end
        return res;
    endfunction

    // a * b
    function automatic logic [31:0] fp32_mul(input logic [31:0] a, input logic [31:0] b);
        logic              sr, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, g, st, rnd;
        logic [47:0]       p;
        logic [23:0]       m;
        logic [24:0]       mr;
        logic signed [9:0] ex;
        logic [31:0]       res;
        sr     = a[31] ^ b[31];
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        p   = '0;
        m   = '0;
        mr  = '0;
        ex  = '0;
        g   = 1'b0;
        st  = 1'b0;
        rnd = 1'b0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) res = FP_QNAN;
        else if (a_inf || b_inf)    res = {sr, 8'hFF, 23'd0};
        else if (a_zero || b_zero)  res = {sr, 31'd0};
        else begin
            p  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
            ex = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
            if (p[47]) begin
                m  = p[47:24];
                g  = p[23];
                st = |p[22:0];
                ex = ex + 10'sd1;
            end else begin
                m  = p[46:23];
                g  = p[22];
                st = |p[21:0];
            end
            rnd = g & (st | m[0]);
            mr  = {1'b0, m} + {24'd0, rnd};
            if (mr[24]) begin
                mr = mr >> 1;
                ex = ex + 10'sd1;
            end
            if (ex >= 10'sd255)      res = {sr, 8'hFF, 23'd0};
            else if (ex <= 10'sd0)   res = {sr, 31'd0};
            else                     res = {sr, ex[7:0], mr[22:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/ifft_pkg.sv
// Shared types, constants and helpers for the sequential 8-point IFFT.
package ifft_pkg;

    localparam int unsigned N_PTS     = 8;
    localparam int unsigned CW        = 64;
    localparam int unsigned FP_SIGN   = 31;
    localparam int unsigned FP_EXP_HI = 30;
    localparam int unsigned FP_EXP_LO = 23;
    localparam logic [7:0]  EXP_MAX   = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STAGE,
        ST_SCALE,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
    } cplx_t;

    // conjugate twiddles W8^-k, {re, im}
    localparam logic [63:0] WI0 = 64'h3F800000_00000000;
    localparam logic [63:0] WI1 = 64'h3F3504F3_3F3504F3;
    localparam logic [63:0] WI2 = 64'h00000000_3F800000;
    localparam logic [63:0] WI3 = 64'hBF3504F3_3F3504F3;

    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    // divide by 8 via exponent; inf/NaN pass, small values flush to signed zero
    function automatic logic [31:0] fp32_div8(input logic [31:0] x);
        logic [7:0] e;
        e = x[FP_EXP_HI:FP_EXP_LO];
        if (e == EXP_MAX)   return x;
        else if (e <= 8'd3) return {x[FP_SIGN], 31'd0};
        else                return {x[FP_SIGN], e - 8'd3, x[FP_EXP_LO-1:0]};
    endfunction

endpackage

// File: rtl/complexAdder.sv
// Complex fp32 adder: y = a + b. Ports are {re[63:32], im[31:0]}.
module complexAdder import fp32_pkg::*; (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] y
);
    assign y = {fp32_add(a[63:32], b[63:32]), fp32_add(a[31:0], b[31:0])};
endmodule

// File: rtl/complexMultiplier.sv
// Complex fp32 multiplier: y = a * b. Ports are {re[63:32], im[31:0]}.
module complexMultiplier import fp32_pkg::*; (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] y
);
    logic [31:0] rr, ii, ri, ir;

    assign rr = fp32_mul(a[63:32], b[63:32]);
    assign ii = fp32_mul(a[31:0],  b[31:0]);
    assign ri = fp32_mul(a[63:32], b[31:0]);
    assign ir = fp32_mul(a[31:0],  b[63:32]);
    assign y  = {fp32_add(rr, {~ii[31], ii[30:0]}), fp32_add(ri, ir)};
endmodule

// File: rtl/ifft_butterfly.sv
// Combinational radix-2 DIT butterfly with conjugate twiddle lookup.
//   a, b     : complex inputs {re, im}
//   tw_idx   : twiddle index k selecting WI0..WI3
//   y_sum_c  : a + b*WI[k]
//   y_dif_c  : a - b*WI[k]
module ifft_butterfly import ifft_pkg::*; (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [1:0]  tw_idx,
    output logic [63:0] y_sum_c,
    output logic [63:0] y_dif_c
);
    logic [63:0] tw, t, t_neg;

    always_comb begin : tw_sel
        tw = WI0;
        case (tw_idx)
            2'd0:    tw = WI0;
            2'd1:    tw = WI1;
            2'd2:    tw = WI2;
            default: tw = WI3;
        endcase
    end

    complexMultiplier u_mul (.a(b), .b(tw), .y(t));

    // negate t by flipping both sign bits
    assign t_neg = {~t[63], t[62:32], ~t[31], t[30:0]};

    complexAdder u_add (.a(a), .b(t),     .y(y_sum_c));
    complexAdder u_sub (.a(a), .b(t_neg), .y(y_dif_c));
endmodule

// File: rtl/ifft8_seq.sv
// Sequential 8-point fp32 inverse FFT, one butterfly per cycle, optional 1/8 scale.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : spectrum handshake, in_data = X0 [511:448] .. X7 [63:0]
//   out_valid/out_ready : result handshake, out_data = x0 .. x7 packed likewise
//   busy                : transform in progress (STAGE or SCALE)
module ifft8_seq import ifft_pkg::*; #(
    parameter bit SCALE_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_data,
    output logic         busy
);
    state_e      state_q, state_d;
    logic [1:0]  s_q, s_d, j_q, j_d;
    cplx_t       buf_q [N_PTS];
    cplx_t       buf_d [N_PTS];
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;

    logic [N_PTS-1:0][CW-1:0] in_words, out_words;
    logic [2:0]  j3, span, pos, idx_i, idx_p;
    logic [1:0]  tw_idx;
    logic [63:0] bf_sum, bf_dif;

    assign in_words  = in_data;
    assign out_data  = out_words;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

    // buffer entry 0 is x0, which sits in the top word
    always_comb begin : out_pack
        for (int k = 0; k < N_PTS; k++) begin
            out_words[3'(N_PTS - 1 - k)] = buf_q[k];
        end
    end

    // butterfly pair and twiddle for stage s, butterfly j
    always_comb begin : addr_gen
        j3     = {1'b0, j_q};
        span   = 3'd1 << s_q;
        pos    = j3 & (span - 3'd1);
        idx_i  = ((j3 >> s_q) << (s_q + 2'd1)) + pos;
        idx_p  = idx_i + span;
        tw_idx = 2'(pos << (2'd2 - s_q));
    end

    ifft_butterfly u_bf (
        .a      (buf_q[idx_i]),
        .b      (buf_q[idx_p]),
        .tw_idx (tw_idx),
        .y_sum_c(bf_sum),
        .y_dif_c(bf_dif)
    );

    // next state, counters, buffer updates and output decode
    always_comb begin : fsm_next
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        buf_d   = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    for (int k = 0; k < N_PTS; k++) begin
                        buf_d[bitrev3(3'(k))] = in_words[3'(N_PTS - 1 - k)];
                    end
                    s_d     = 2'd0;
                    j_d     = 2'd0;
                    state_d = ST_STAGE;
                end
            end
            ST_STAGE: begin
                buf_d[idx_i] = bf_sum;
                buf_d[idx_p] = bf_dif;
                if (j_q == 2'd3) begin
                    j_d = 2'd0;
                    if (s_q == 2'd2) begin
                        s_d     = 2'd0;
                        state_d = ST_SCALE;
                    end else begin
                        s_d = s_q + 2'd1;
                    end
                end else begin
                    j_d = j_q + 2'd1;
                end
            end
            ST_SCALE: begin
                if (SCALE_EN) begin
                    for (int k = 0; k < N_PTS; k++) begin
                        buf_d[k].re = fp32_div8(buf_q[k].re);
                        buf_d[k].im = fp32_div8(buf_q[k].im);
                    end
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_STAGE) || (state_d == ST_SCALE);
    end

    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            s_q         <= 2'd0;
            j_q         <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 0; k < N_PTS; k++) buf_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            j_q         <= j_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            for (int k = 0; k < N_PTS; k++) buf_q[k] <= buf_d[k];
        end
    end

endmodule
